z_accumulator: RTL and testbench
================================

Name: z_accumulator

Overview:
- Downstream stage of the 64x64+128 multiply-add datapath; consumes one 128-bit Z result per handshake beat.
- Sums a vector of Z terms, with the vector end marked by z_last.
- Presents the widened sum, term count and overflow flag on a valid/ready output port.
- Forms the dot-product accumulation layer above the combinational equation stage.

Parameters:
- ZW, 128, width of incoming Z term.
- GUARD, 8, extra accumulator bits above ZW; ACCW = ZW+GUARD.
- MAX_TERMS, 256, maximum terms per vector; CW = $clog2(MAX_TERMS+1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- z_valid  input  1  Z term present
- z_ready  output  1  block can accept a term
- z_data  input  ZW  unsigned Z term
- z_last  input  1  final term of vector (qualified by z_valid)
- clear  input  1  synchronous abort of current vector
- acc_valid  output  1  result available
- acc_ready  input  1  consumer takes result
- acc_data  output  ACCW  unsigned sum
- acc_count  output  CW  number of terms summed
- acc_ovf  output  1  sticky overflow for this vector

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, acc_data=0, acc_count=0, acc_ovf=0, acc_valid=0.
- Beat rule: a beat is accepted when z_valid && z_ready on a rising edge.
- FSM states: IDLE, ACC, DONE.
  - z_ready = (state != DONE), decoded combinationally.
  - acc_valid = (state == DONE).
  - During reset the state is IDLE, so z_ready reads 1, but no beat is accepted while rst_n is low.
- IDLE + beat: sum <= zero-extended z_data, count <= 1, ovf <= 0. Next state is DONE if z_last, else ACC.
- ACC + beat: sum <= sum + z_data (ACCW-bit add, carry-out captured), count <= count+1. Next state is DONE if z_last, else ACC.
- DONE: outputs held stable while acc_ready=0. When acc_ready=1, go to IDLE. acc_data, acc_count and acc_ovf keep their values until the next vector starts.
- Latency: acc_valid rises the cycle after the z_last beat is accepted.
- Throughput: one term per cycle. One bubble per vector (DONE blocks input for at least one cycle).
- Overflow: acc_ovf is set on any add carry-out beyond ACCW bits. It is also set when a beat would make count exceed MAX_TERMS; in that case count holds at MAX_TERMS and the sum still accumulates. acc_ovf is sticky until the next vector starts or clear.
- clear (synchronous, highest priority, any state):
  - state <= IDLE; sum, count and ovf <= 0.
  - A coincident z beat is dropped.
  - In DONE the pending result is discarded and acc_valid falls next cycle.
- Async reset mid-vector or in DONE: all state is discarded immediately and acc_valid drops asynchronously.
- z_last in IDLE gives a one-term vector.
- z_data is unsigned; no sign extension.

Optional Feature:
- Macro: Z_ACC_SAT_EN.
- Defined: on overflow acc_data clamps to all-ones (ACCW bits) and remains clamped for the rest of the vector.
- Undefined: acc_data wraps modulo 2^ACCW.
- acc_ovf behaves identically in both builds.

Decomposition:
- Package z_acc_pkg holds:
  - ZW, GUARD, ACCW, MAX_TERMS, CW localparams.
  - State typedef enum logic [1:0] {IDLE, ACC, DONE}.
- Sub-module acc_adder: ACCW-bit adder with zero-extended ZW operand, carry_out, and saturation mux under Z_ACC_SAT_EN.
- FSM, counter and output registers stay in z_accumulator.

Test Plan:
- Reset, one beat z_data=128'h1 with z_last=1 -> next cycle acc_valid=1, acc_data=136'h1, acc_count=1, acc_ovf=0. With acc_ready=1 the block returns to IDLE and z_ready=1.
- Three beats of 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, last on the third -> acc_data=136'h02_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD, acc_count=3, acc_ovf=0.
- Backpressure: hold acc_ready=0 for 5 cycles in DONE while z_valid=1 -> acc_valid, acc_data and acc_count stay stable, z_ready=0, and no term is absorbed. Releasing acc_ready lets the waiting term start a new vector.
- Two beats 128'h10 and 128'h20, then a third beat 128'h40 coincident with clear=1, then beat 128'h5 with last -> acc_data=136'h5, acc_count=1.
- GUARD=1 instance, three all-ones terms, last on the third:
  - Wrap build -> acc_data=129'h0_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD, acc_ovf=1.
  - Z_ACC_SAT_EN build -> acc_data all-ones, acc_ovf=1.
- Drop rst_n asynchronously while in DONE -> acc_valid=0 and acc_count=0 with no clock edge. Then a one-term vector of 128'h7 -> acc_data=136'h7.

Source files
------------

// File: rtl/z_acc_pkg.sv
// z_acc_pkg: shared widths and FSM state encoding for the Z accumulator slice
//   ZW        width of one incoming Z term
//   GUARD     accumulator headroom bits above ZW
//   ACCW      accumulator width (ZW+GUARD)
//   MAX_TERMS largest term count a vector may carry
//   CW        width of the term counter
package z_acc_pkg;
    localparam int ZW        = 128;
    localparam int GUARD     = 8;
    localparam int ACCW      = ZW + GUARD;
    localparam int MAX_TERMS = 256;
    localparam int CW        = $clog2(MAX_TERMS + 1);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/acc_adder.sv
// acc_adder: ACCW-bit add of a zero-extended ZW term, with optional clamp (Z_ACC_SAT_EN)
//   a      running sum
//   b      unsigned Z term, zero-extended
//   hold   (Z_ACC_SAT_EN only) vector already overflowed, keep clamped
//   sum    next running sum
//   carry  carry-out beyond ACCW bits
module acc_adder #(
    parameter int ZW   = 128,
    parameter int ACCW = 136
) (
    input  logic [ACCW-1:0] a,
    input  logic [ZW-1:0]   b,
`ifdef Z_ACC_SAT_EN
    input  logic            hold,
`endif
    output logic [ACCW-1:0] sum,
    output logic            carry
);
    logic [ACCW-1:0] raw;
    assign {carry, raw} = {1'b0, a} + (ACCW+1)'(b);
`ifdef Z_ACC_SAT_EN
    assign sum = (carry || hold) ? '1 : raw;
`else
    assign sum = raw;
`endif
endmodule

// File: rtl/z_accumulator.sv
// z_accumulator: sums a z_last-terminated vector of Z terms; optional clamp via Z_ACC_SAT_EN
//   clk, rst_n           clock, async active-low reset
//   z_valid/z_ready      input handshake; z_data term, z_last marks final term
//   clear                sync abort of the current vector (highest priority)
//   acc_valid/acc_ready  result handshake
//   acc_data             sum, acc_count terms summed, acc_ovf sticky overflow
module z_accumulator #(
    parameter int ZW        = z_acc_pkg::ZW,
    parameter int GUARD     = z_acc_pkg::GUARD,
    parameter int MAX_TERMS = z_acc_pkg::MAX_TERMS,
    localparam int ACCW     = ZW + GUARD,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            z_valid,
    output logic            z_ready,
    input  logic [ZW-1:0]   z_data,
    input  logic            z_last,
    input  logic            clear,
    output logic            acc_valid,
    input  logic            acc_ready,
    output logic [ACCW-1:0] acc_data,
    output logic [CW-1:0]   acc_count,
    output logic            acc_ovf
);
    import z_acc_pkg::*;

    state_t          state;
    logic [ACCW-1:0] add_sum;
    logic            carry;
    logic            full;

    assign z_ready   = (state != DONE);
    assign acc_valid = (state == DONE);
    // a further term beyond MAX_TERMS overflows the counter
    assign full      = (acc_count == CW'(MAX_TERMS));

    acc_adder #(.ZW(ZW), .ACCW(ACCW)) u_add (
        .a     (acc_data),
        .b     (z_data),
`ifdef Z_ACC_SAT_EN
        .hold  (acc_ovf || full),
`endif
        .sum   (add_sum),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_data  <= '0;
            acc_count <= '0;
            acc_ovf   <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc_data  <= '0;
            acc_count <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (z_valid) begin
                    acc_data  <= ACCW'(z_data);
                    acc_count <= CW'(1);
                    acc_ovf   <= 1'b0;
                    state     <= z_last ? DONE : ACC;
                end
                ACC: if (z_valid) begin
                    acc_data  <= add_sum;
                    acc_count <= full ? acc_count : acc_count + CW'(1);
                    acc_ovf   <= acc_ovf || carry || full;
                    state     <= z_last ? DONE : ACC;
                end
                DONE: if (acc_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_z_accumulator.sv
// tb_z_accumulator: directed checks of the Z accumulator (default and GUARD=1 instances)
module tb_z_accumulator;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic         clk = 0;
    logic         rst_n = 0;
    logic         z_valid = 0, z_last = 0, clear = 0, acc_ready = 0;
    logic [127:0] z_data = '0;
    logic         z_ready, acc_valid, acc_ovf;
    logic [135:0] acc_data;
    logic [8:0]   acc_count;

    logic         b_valid = 0, b_last = 0;
    logic [127:0] b_data = '0;
    logic         b_ready, b_acc_valid, b_ovf;
    logic [128:0] b_acc;
    logic [8:0]   b_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    z_accumulator dut (
        .clk(clk), .rst_n(rst_n), .z_valid(z_valid), .z_ready(z_ready),
        .z_data(z_data), .z_last(z_last), .clear(clear),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
        .acc_count(acc_count), .acc_ovf(acc_ovf)
    );

    z_accumulator #(.GUARD(1)) dut_g1 (
        .clk(clk), .rst_n(rst_n), .z_valid(b_valid), .z_ready(b_ready),
        .z_data(b_data), .z_last(b_last), .clear(1'b0),
        .acc_valid(b_acc_valid), .acc_ready(1'b0), .acc_data(b_acc),
        .acc_count(b_count), .acc_ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [127:0] d, input logic last);
        z_valid = 1; z_data = d; z_last = last;
        @(posedge clk); #1;
        z_valid = 0; z_last = 0;
    endtask

    task automatic pop();
        acc_ready = 1;
        @(posedge clk); #1;
        acc_ready = 0;
    endtask

    initial begin
        #1;
        check("rst_valid", 136'(acc_valid), 136'd0);
        check("rst_data", acc_data, 136'd0);
        check("rst_count", 136'(acc_count), 136'd0);
        check("rst_ovf", 136'(acc_ovf), 136'd0);
        check("rst_zready", 136'(z_ready), 136'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;

        beat(128'h1, 1);
        check("one_valid", 136'(acc_valid), 136'd1);
        check("one_data", acc_data, 136'h1);
        check("one_count", 136'(acc_count), 136'd1);
        check("one_ovf", 136'(acc_ovf), 136'd0);
        check("one_zready", 136'(z_ready), 136'd0);
        pop();
        check("pop_valid", 136'(acc_valid), 136'd0);
        check("pop_zready", 136'(z_ready), 136'd1);

        beat(ONES, 0);
        beat(ONES, 0);
        beat(ONES, 1);
        check("three_data", acc_data, 136'h02_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD);
        check("three_count", 136'(acc_count), 136'd3);
        check("three_ovf", 136'(acc_ovf), 136'd0);

        z_valid = 1; z_data = 128'h9; z_last = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 136'(acc_valid), 136'd1);
            check("bp_data", acc_data, 136'h02_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD);
            check("bp_count", 136'(acc_count), 136'd3);
            check("bp_zready", 136'(z_ready), 136'd0);
        end
        acc_ready = 1;
        @(posedge clk); #1;
        acc_ready = 0;
        check("rel_valid", 136'(acc_valid), 136'd0);
        @(posedge clk); #1;
        z_valid = 0; z_last = 0;
        check("rel_data", acc_data, 136'h9);
        check("rel_count", 136'(acc_count), 136'd1);
        check("rel_valid2", 136'(acc_valid), 136'd1);
        pop();

        beat(128'h10, 0);
        beat(128'h20, 0);
        check("mid_data", acc_data, 136'h30);
        check("mid_count", 136'(acc_count), 136'd2);
        z_valid = 1; z_data = 128'h40; clear = 1;
        @(posedge clk); #1;
        z_valid = 0; clear = 0;
        check("clr_data", acc_data, 136'd0);
        check("clr_count", 136'(acc_count), 136'd0);
        check("clr_valid", 136'(acc_valid), 136'd0);
        beat(128'h5, 1);
        check("aft_clr_data", acc_data, 136'h5);
        check("aft_clr_count", 136'(acc_count), 136'd1);
        pop();

        b_valid = 1; b_data = ONES;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_last = 1;
        @(posedge clk); #1;
        b_valid = 0; b_last = 0;
        check("g1_valid", 136'(b_acc_valid), 136'd1);
`ifdef Z_ACC_SAT_EN
        check("g1_data", 136'(b_acc), {7'd0, {129{1'b1}}});
`else
        check("g1_data", 136'(b_acc), 136'h0_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFD);
`endif
        check("g1_ovf", 136'(b_ovf), 136'd1);

        z_valid = 1; z_data = 128'h1;
        for (int i = 0; i < 257; i++) begin
            z_last = (i == 256);
            @(posedge clk); #1;
        end
        z_valid = 0; z_last = 0;
        check("max_count", 136'(acc_count), 136'd256);
        check("max_ovf", 136'(acc_ovf), 136'd1);
`ifdef Z_ACC_SAT_EN
        check("max_data", acc_data, {136{1'b1}});
`else
        check("max_data", acc_data, 136'd257);
`endif

        check("pre_rst_valid", 136'(acc_valid), 136'd1);
        #2 rst_n = 0;
        #1;
        check("arst_valid", 136'(acc_valid), 136'd0);
        check("arst_count", 136'(acc_count), 136'd0);
        check("arst_ovf", 136'(acc_ovf), 136'd0);
        @(posedge clk); #1;
        rst_n = 1;
        beat(128'h7, 1);
        check("post_data", acc_data, 136'h7);
        check("post_count", 136'(acc_count), 136'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
